counter_mod: RTL
================

// Module: counter_mod
// PURPOSE
//  Parametrised modulo-N counter digit for the clock datapath (seconds/minutes/hours digits).
//  Counts 0..MODULUS-1 with wrap, sync clear, sync load, and a combinational carry for cascading.
//  Chains of instances form the time-of-day counter; the load path serves time-setting.
// PARAMETERS
//  WIDTH      4  counter width in bits
//  MODULUS    6  count modulus; legal range 2..2**WIDTH
//  RESET_VAL  0  q value after reset and after clr; must be < MODULUS
//  Illegal MODULUS or RESET_VAL -> elaboration error (generate-time $error/initial check).
// PORTS
//  clk     in   1      rising-edge clock
//  rst_n   in   1      async reset, active-low
//  clr     in   1      sync clear, active-high; q <= RESET_VAL
//  en      in   1      count enable, active-high; one step per enabled clk
//  ld      in   1      sync load strobe, active-high
//  ld_val  in   WIDTH  value to load when ld=1
//  dn      in   1      direction, 1 = down (port exists only with COUNTER_MOD_UPDOWN_EN)
//  q       out  WIDTH  registered count value
//  co      out  1      combinational carry/borrow = en & terminal (see below); feeds next digit's en
//  ld_err  out  1      registered one-cycle pulse: rejected load (ld_val >= MODULUS)
// BEHAVIOUR
//  - Clocking: single clk domain; all state updates on posedge clk except rst_n.
//  - Reset: rst_n=0 asynchronously forces q=RESET_VAL, ld_err=0; co follows from q/en.
//  - Priority per edge: clr > ld > en > hold.
//    clr=1           : q <= RESET_VAL; ld_err <= 0; ld and en ignored.
//    ld=1, legal     : q <= ld_val; ld_err <= 0; en ignored this cycle.
//    ld=1, illegal   : ld_val >= MODULUS -> q holds, ld_err <= 1 for exactly one cycle.
//    en=1 (up)       : q == MODULUS-1 ? q <= 0 : q <= q+1.
//    en=0            : q holds; ld_err <= 0.
//  - Terminal: up -> q == MODULUS-1; down -> q == 0.
//  - co = en & terminal & ~clr & ~ld; combinational, same-cycle, no registered latency.
//    Cascade: next digit's en = this co; the whole chain advances on the same edge.
//  - Latency: q updates one clk after strobe; co valid in the cycle the wrap edge occurs.
//  - Arithmetic: increments/decrements at WIDTH bits; q never leaves 0..MODULUS-1
//    (a full-range MODULUS = 2**WIDTH wraps naturally, with no compare overflow).
//  - Reset mid-count: rst_n assertion aborts immediately; after release the first
//    enabled edge steps from RESET_VAL.
//  - Simultaneous clr+ld+en: clr wins; co=0 that cycle; ld_err=0.
// CONFIGURATION
//  COUNTER_MOD_UPDOWN_EN defined:
//    dn port present; dn=1 and en=1: q == 0 ? q <= MODULUS-1 : q <= q-1;
//    co means borrow (en & dn & q==0); dn sampled each edge, may change any cycle.
//  COUNTER_MOD_UPDOWN_EN undefined:
//    no dn port; up-count only; co = en & (q == MODULUS-1) under the same masks.
// TESTING
//  1 Reset: rst_n=0 mid-count at q=3, asynchronously -> q=0 before next edge, ld_err=0.
//  2 Wrap: MODULUS=6, en=1 for 7 edges from 0 -> q 1,2,3,4,5,0,1; co=1 only while q=5.
//  3 Load: ld=1, ld_val=4 -> q=4, ld_err=0; ld_val=7 -> q holds, ld_err=1 for one cycle only.
//  4 Priority: clr=ld=en=1 at q=5 -> q=0, co=0, ld_err=0; ld=en=1, ld_val=2 -> q=2.
//  5 Cascade: two instances (MOD 10, MOD 6), en=1 -> 59 -> 00 on one edge; co chain correct.
//  6 UPDOWN_EN: dn=1 at q=0 -> q=5, co=1; toggle dn each cycle from 3 -> 2,3,2,3.

Source files
------------

// File: rtl/counter_mod_if.sv
// Control/status bundle for one counter_mod digit.
// COUNTER_MOD_UPDOWN_EN adds the dn direction input.
interface counter_mod_if #(
  parameter int WIDTH = 4
);
  logic             clr;
  logic             en;
  logic             ld;
  logic [WIDTH-1:0] ld_val;
`ifdef COUNTER_MOD_UPDOWN_EN
  logic             dn;
`endif
  logic [WIDTH-1:0] q;
  logic             co;
  logic             ld_err;

`ifdef COUNTER_MOD_UPDOWN_EN
  modport master (
    output clr, en, ld, ld_val, dn,
    input  q, co, ld_err
  );
  modport slave (
    input  clr, en, ld, ld_val, dn,
    output q, co, ld_err
  );
`else
  modport master (
    output clr, en, ld, ld_val,
    input  q, co, ld_err
  );
  modport slave (
    input  clr, en, ld, ld_val,
    output q, co, ld_err
  );
`endif
endinterface

// File: rtl/counter_mod.sv
// Modulo-N counter digit with clear, checked load and cascade carry.
// COUNTER_MOD_UPDOWN_EN enables down-counting via bus.dn.
module counter_mod #(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 6,
  parameter int RESET_VAL = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  counter_mod_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);

  if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_mod
    $error("counter_mod: MODULUS out of range 2..2**WIDTH");
  end
  if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_rst
    $error("counter_mod: RESET_VAL must be in 0..MODULUS-1");
  end

  logic [WIDTH-1:0] q_q, q_d;
  logic             ld_err_q, ld_err_d;
  logic             ld_bad;
  logic             term;
  logic [WIDTH-1:0] q_step;

  always_comb begin
    // widened compare keeps MODULUS = 2**WIDTH from overflowing
    ld_bad = 32'(bus.ld_val) >= $unsigned(MODULUS);
`ifdef COUNTER_MOD_UPDOWN_EN
    if (bus.dn) begin
      term   = (q_q == '0);
      q_step = term ? MAX_V : q_q - WIDTH'(1);
    end else begin
      term   = (q_q == MAX_V);
      q_step = term ? '0 : q_q + WIDTH'(1);
    end
`else
    term   = (q_q == MAX_V);
    q_step = term ? '0 : q_q + WIDTH'(1);
`endif
  end

  always_comb begin
    q_d      = q_q;
    ld_err_d = 1'b0;
    if (bus.clr) begin
      q_d = RST_V;
    end else if (bus.ld) begin
      if (ld_bad) ld_err_d = 1'b1;
      else        q_d      = bus.ld_val;
    end else if (bus.en) begin
      q_d = q_step;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q      <= RST_V;
      ld_err_q <= 1'b0;
    end else begin
      q_q      <= q_d;
      ld_err_q <= ld_err_d;
    end
  end

  assign bus.q      = q_q;
  assign bus.ld_err = ld_err_q;
  assign bus.co     = bus.en & term & ~bus.clr & ~bus.ld;

endmodule
